// File: rtl/fv_pkg.sv
// Shared types and helpers for the ciphertext adder datapath.
package fv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fsm_state_t;

  // Message scale factor: 2^(qw-mw).
  function automatic int unsigned delta_of(input int unsigned qw, input int unsigned mw);
    return 32'd1 << (qw - mw);
  endfunction

endpackage

// File: rtl/coeff_fifo.sv
// Small synchronous FIFO holding product coefficients (data plus last bit).
module coeff_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             a_rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ct_adder.sv
// Ciphertext coefficient adder: c = z + sign_ext(e) + m*DELTA (mod 2^QW),
// with product buffering, polynomial framing checks and overflow fault state.
module ct_adder
  import fv_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned QW = 5,
  parameter int unsigned EW = 3,
  parameter int unsigned MW = 1
) (
  input  logic          clk,
  input  logic          a_rst_n,
  input  logic          z_vld,
  output logic          z_rdy,
  input  logic [QW-1:0] z,
  input  logic          z_last,
  input  logic          e_vld,
  output logic          e_rdy,
  input  logic [EW-1:0] e,
  input  logic          e_last,
  input  logic          m_vld,
  output logic          m_rdy,
  input  logic [MW-1:0] m,
  input  logic          m_last,
  output logic          c_vld,
  input  logic          c_rdy,
  output logic [QW-1:0] c,
  output logic          c_last,
  output logic          err
);

  localparam int unsigned DELTA = delta_of(QW, MW);
  localparam int unsigned CNTW  = $clog2(N);
  localparam int unsigned FW    = QW + 1;

  fsm_state_t      state;
  fsm_state_t      state_nxt;
  logic            push;
  logic            fire;
  logic            overflow;
  logic            fifo_full;
  logic            fifo_empty;
  logic [FW-1:0]   fifo_rdata;
  logic [QW-1:0]   fifo_z;
  logic            fifo_last;
  logic [CNTW-1:0] cnt;
  logic            at_end;
  logic            misalign;
  logic [QW-1:0]   sum;

  coeff_fifo #(
    .DEPTH (N),
    .WIDTH (FW)
  ) u_fifo (
    .clk     (clk),
    .a_rst_n (a_rst_n),
    .push    (push),
    .pop     (fire),
    .wdata   ({z_last, z}),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign fifo_z    = fifo_rdata[QW-1:0];
  assign fifo_last = fifo_rdata[QW];

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Handshakes are only open in RUN; an ignored backpressure traps in FAULT.
  always_comb begin
    state_nxt = state;
    z_rdy     = 1'b0;
    e_rdy     = 1'b0;
    m_rdy     = 1'b0;
    push      = 1'b0;
    fire      = 1'b0;
    overflow  = 1'b0;
    case (state)
      IDLE: state_nxt = RUN;
      RUN: begin
        z_rdy    = !fifo_full;
        push     = z_vld && !fifo_full;
        overflow = z_vld && fifo_full;
        fire     = !fifo_empty && e_vld && m_vld && (!c_vld || c_rdy);
        e_rdy    = fire;
        m_rdy    = fire;
        if (overflow) state_nxt = FAULT;
      end
      FAULT:   state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  assign at_end   = (cnt == CNTW'(N - 1));
  assign misalign = fire && ((fifo_last != at_end) || (e_last != at_end) || (m_last != at_end));
  assign sum      = fifo_z + QW'($signed(e)) + QW'(DELTA * 32'(m));

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      c      <= '0;
      c_vld  <= 1'b0;
      c_last <= 1'b0;
      err    <= 1'b0;
      cnt    <= '0;
    end else begin
      if (overflow || misalign) err <= 1'b1;
      if (fire) cnt <= at_end ? '0 : cnt + CNTW'(1);
      if (state == FAULT || overflow) begin
        c_vld <= 1'b0;
      end else if (fire) begin
        c      <= sum;
        c_vld  <= 1'b1;
        c_last <= at_end;
      end else if (c_rdy) begin
        c_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ct_adder.sv
// Directed bench for ct_adder at N=4, QW=5, EW=3, MW=1 (DELTA=16).
module tb_ct_adder;

  localparam int unsigned N  = 4;
  localparam int unsigned QW = 5;
  localparam int unsigned EW = 3;
  localparam int unsigned MW = 1;

  logic          clk;
  logic          a_rst_n;
  logic          z_vld, z_rdy, z_last;
  logic [QW-1:0] z;
  logic          e_vld, e_rdy, e_last;
  logic [EW-1:0] e;
  logic          m_vld, m_rdy, m_last;
  logic [MW-1:0] m;
  logic          c_vld, c_rdy, c_last;
  logic [QW-1:0] c;
  logic          err;

  int n_checks = 0;
  int n_pass   = 0;

  int fp_z [4] = '{5, 9, 20, 31};
  int fp_e [4] = '{1, -2, 3, -1};
  int fp_m [4] = '{0, 1, 1, 0};
  int fp_c [4] = '{6, 23, 7, 30};
  int bp_z [4] = '{4, 8, 12, 16};

  ct_adder #(.N(N), .QW(QW), .EW(EW), .MW(MW)) dut (
    .clk     (clk),
    .a_rst_n (a_rst_n),
    .z_vld   (z_vld),
    .z_rdy   (z_rdy),
    .z       (z),
    .z_last  (z_last),
    .e_vld   (e_vld),
    .e_rdy   (e_rdy),
    .e       (e),
    .e_last  (e_last),
    .m_vld   (m_vld),
    .m_rdy   (m_rdy),
    .m       (m),
    .m_last  (m_last),
    .c_vld   (c_vld),
    .c_rdy   (c_rdy),
    .c       (c),
    .c_last  (c_last),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // One coefficient through an idle pipe: push, fire on the next edge, check.
  task automatic single(input string tag, input logic [4:0] zv, input logic [2:0] ev,
                        input logic mv, input logic zl, input logic el, input logic ml,
                        input logic [4:0] exp_c, input logic exp_last);
    @(negedge clk);
    z_vld = 1'b1; z = zv; z_last = zl;
    e_vld = 1'b1; e = ev; e_last = el;
    m_vld = 1'b1; m = mv; m_last = ml;
    c_rdy = 1'b1;
    @(negedge clk);
    z_vld = 1'b0; z_last = 1'b0;
    check({tag, "_pre_vld"}, 32'(c_vld), 32'd0);
    @(negedge clk);
    check({tag, "_c"}, 32'(c), 32'(exp_c));
    check({tag, "_vld"}, 32'(c_vld), 32'd1);
    check({tag, "_last"}, 32'(c_last), 32'(exp_last));
    e_vld = 1'b0; m_vld = 1'b0; e_last = 1'b0; m_last = 1'b0;
  endtask

  initial begin
    a_rst_n = 1'b0;
    z_vld = 1'b0; z = '0; z_last = 1'b0;
    e_vld = 1'b0; e = '0; e_last = 1'b0;
    m_vld = 1'b0; m = '0; m_last = 1'b0;
    c_rdy = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_z_rdy", 32'(z_rdy), 32'd0);
    check("rst_c_vld", 32'(c_vld), 32'd0);
    check("rst_c", 32'(c), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    a_rst_n = 1'b1;
    #1 check("idle_z_rdy", 32'(z_rdy), 32'd0);
    @(negedge clk);
    check("run_z_rdy", 32'(z_rdy), 32'd1);

    // Basic sum and wrap-around cases, closing a polynomial on the fourth.
    single("basic", 5'd3, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 5'd18, 1'b0);
    single("wrap1", 5'd31, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd17, 1'b0);
    single("wrap2", 5'd0, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 5'd28, 1'b0);
    single("close", 5'd10, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd11, 1'b1);
    check("close_err", 32'(err), 32'd0);

    // Full polynomial back-to-back.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        check($sformatf("poly_c%0d", k - 2), 32'(c), 32'(fp_c[k-2]));
        check($sformatf("poly_vld%0d", k - 2), 32'(c_vld), 32'd1);
        check($sformatf("poly_last%0d", k - 2), 32'(c_last), 32'((k - 2) == 3));
      end
      if (k < 4) begin
        z_vld = 1'b1; z = 5'(fp_z[k]); z_last = (k == 3);
      end else begin
        z_vld = 1'b0; z_last = 1'b0;
      end
      if (k >= 1 && k <= 4) begin
        e_vld = 1'b1; e = 3'(fp_e[k-1]); e_last = ((k - 1) == 3);
        m_vld = 1'b1; m = 1'(fp_m[k-1]); m_last = ((k - 1) == 3);
      end else begin
        e_vld = 1'b0; e_last = 1'b0; m_vld = 1'b0; m_last = 1'b0;
      end
    end
    @(negedge clk);
    check("poly_idle_vld", 32'(c_vld), 32'd0);
    check("poly_err", 32'(err), 32'd0);

    // Backpressure: fill the buffer with the output blocked, then drain in order.
    c_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      z_vld = 1'b1; z = 5'(bp_z[k]); z_last = (k == 3);
    end
    @(negedge clk);
    z_vld = 1'b0; z_last = 1'b0;
    check("bp_full_z_rdy", 32'(z_rdy), 32'd0);
    check("bp_no_vld", 32'(c_vld), 32'd0);
    e_vld = 1'b1; e = '0; e_last = 1'b0;
    m_vld = 1'b1; m = '0; m_last = 1'b0;
    @(negedge clk);
    check("bp_first_c", 32'(c), 32'(bp_z[0]));
    check("bp_first_vld", 32'(c_vld), 32'd1);
    check("bp_reopen_z_rdy", 32'(z_rdy), 32'd1);
    @(negedge clk);
    check("bp_hold_c", 32'(c), 32'(bp_z[0]));
    check("bp_hold_vld", 32'(c_vld), 32'd1);
    check("bp_hold_e_rdy", 32'(e_rdy), 32'd0);
    c_rdy = 1'b1;
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      check($sformatf("bp_c%0d", j), 32'(c), 32'(bp_z[j]));
      check($sformatf("bp_last%0d", j), 32'(c_last), 32'(j == 3));
      e_last = ((j + 1) == 3); m_last = ((j + 1) == 3);
    end
    e_vld = 1'b0; m_vld = 1'b0; e_last = 1'b0; m_last = 1'b0;
    @(negedge clk);
    check("bp_drained_vld", 32'(c_vld), 32'd0);
    check("bp_err", 32'(err), 32'd0);

    // Misaligned e_last on the second coefficient.
    single("mis0", 5'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0);
    single("mis1", 5'd2, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0);
    check("mis_err", 32'(err), 32'd1);
    single("mis2", 5'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0);
    single("mis3", 5'd4, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1);

    // Reset mid-polynomial with a held output and a buffered product.
    single("pre0", 5'd5, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0);
    single("pre1", 5'd6, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd6, 1'b0);
    c_rdy = 1'b0; z_vld = 1'b1; z = 5'd9;
    @(negedge clk);
    z_vld = 1'b0;
    check("pre_rst_vld", 32'(c_vld), 32'd1);
    a_rst_n = 1'b0;
    #1;
    check("async_c_vld", 32'(c_vld), 32'd0);
    check("async_c", 32'(c), 32'd0);
    check("async_err", 32'(err), 32'd0);
    check("async_z_rdy", 32'(z_rdy), 32'd0);
    @(negedge clk);
    a_rst_n = 1'b1; c_rdy = 1'b1;
    @(negedge clk);
    single("post0", 5'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0);
    single("post1", 5'd4, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 1'b0);
    single("post2", 5'd6, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd6, 1'b0);
    single("post3", 5'd8, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1);
    check("post_err", 32'(err), 32'd0);

    // Overflow: a fifth product while full traps the block in FAULT.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      z_vld = 1'b1; z = 5'(k + 1);
    end
    @(negedge clk);
    check("ovf_full_z_rdy", 32'(z_rdy), 32'd0);
    @(negedge clk);
    z_vld = 1'b0;
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_c_vld", 32'(c_vld), 32'd0);
    e_vld = 1'b1; m_vld = 1'b1; c_rdy = 1'b1;
    #1;
    check("fault_e_rdy", 32'(e_rdy), 32'd0);
    check("fault_m_rdy", 32'(m_rdy), 32'd0);
    repeat (3) @(negedge clk);
    check("fault_hold_c_vld", 32'(c_vld), 32'd0);
    check("fault_hold_z_rdy", 32'(z_rdy), 32'd0);
    check("fault_hold_err", 32'(err), 32'd1);
    e_vld = 1'b0; m_vld = 1'b0;
    a_rst_n = 1'b0;
    @(negedge clk);
    a_rst_n = 1'b1;
    check("recover_err", 32'(err), 32'd0);
    @(negedge clk);
    check("recover_z_rdy", 32'(z_rdy), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ct_adder.md
CT_ADDER -- requirements
Module: ct_adder

Interface
REQ-001 SHALL have parameter N, default 4: coefficients per polynomial, power of two >= 2.
REQ-002 SHALL have parameter QW, default 5: coefficient width; modulus q = 2^QW.
REQ-003 SHALL have parameter EW, default 3: error-sample width, two's complement.
REQ-004 SHALL have parameter MW, default 1: message-coefficient width, MW < QW; scale DELTA = 2^(QW-MW).
REQ-005 SHALL have ports:
 - clk  in  1  sole clock; all logic on rising edge.
 - a_rst_n  in  1  asynchronous, active-low reset.
 - z_vld  in  1  product coefficient valid, from the upstream multiplier.
 - z_rdy  out  1  space available in the product buffer.
 - z  in  QW  product coefficient.
 - z_last  in  1  last product coefficient of a polynomial.
 - e_vld / e_rdy / e / e_last  in/out/EW/in  error-sample stream.
 - m_vld / m_rdy / m / m_last  in/out/MW/in  message-coefficient stream.
 - c_vld / c_rdy / c / c_last  out/in/QW/out  ciphertext-coefficient stream.
 - err  out  1  sticky protocol-fault flag.

Function
REQ-006 SHALL buffer z in an N-entry FIFO (data plus last bit); push when z_vld && z_rdy; z_rdy = FIFO not full && state RUN.
REQ-007 SHALL fire when FIFO non-empty && e_vld && m_vld && (!c_vld || c_rdy) in RUN; e_rdy = m_rdy = fire; a fire pops one FIFO entry.
REQ-008 SHALL on fire load c <= (z + sign_ext(e) + m*DELTA) mod 2^QW and set c_vld; the mod-2^QW wrap is the truncation to QW bits.
REQ-009 SHALL clear c_vld when c_rdy && !fire; c, c_vld, and c_last SHALL hold stable while c_vld && !c_rdy.
REQ-010 SHALL give latency: z accepted at edge t, with e and m valid and the output free, yields c_vld high after edge t+1; sustained throughput is 1 coefficient/cycle.
REQ-011 SHALL keep a coefficient counter 0..N-1, advanced on fire, wrapping to 0 after N-1; c_last = 1 for the coefficient fired at count N-1.
REQ-012 SHALL treat simultaneous push and pop on a non-empty FIFO as occupancy unchanged; FIFO pointers wrap modulo N.
REQ-013 SHALL, on fire, set err if the popped z_last, e_last, or m_last differs from (count == N-1); the data path continues, and c_last follows the counter.
REQ-014 SHALL treat z_vld high while z_rdy is low (the upstream ignores backpressure) as overflow: set err, drop the sample, enter FAULT.
REQ-015 SHALL have FSM states IDLE, RUN, FAULT:
 - IDLE -> RUN one cycle after reset release.
 - RUN -> FAULT on overflow.
 - FAULT is exited only by reset.
REQ-016 SHALL, in IDLE and FAULT, hold z_rdy = e_rdy = m_rdy = 0; in FAULT, force c_vld = 0.

Reset
REQ-017 SHALL on a_rst_n low immediately clear, without waiting for clk, all of the following: z_rdy, e_rdy, m_rdy, c_vld, c, c_last, err, FIFO pointers and occupancy, counter; FSM goes to IDLE.
REQ-018 SHALL discard any partial polynomial when reset is asserted mid-operation; the first coefficient after reset SHALL be counted as index 0.

Structure
REQ-019 SHALL place the FSM state typedef (IDLE/RUN/FAULT) and the DELTA computation function in shared package fv_pkg.
REQ-020 SHALL implement the buffer as sub-module coeff_fifo (parameters DEPTH, WIDTH; full/empty flags; asynchronous active-low reset).

Verification (N=4, QW=5, EW=3, MW=1, DELTA=16)
REQ-021 SHALL cover basic sum: z=3, e=3'b111 (-1), m=1 -> c=18, one cycle after the fire edge.
REQ-022 SHALL cover wrap-around: z=31, e=2, m=1 -> c=17; z=0, e=3'b100 (-4), m=0 -> c=28.
REQ-023 SHALL cover a full polynomial: 4 z with z_last on the 4th, e and m streams always valid, c_rdy=1 -> 4 back-to-back c, c_last on the 4th only, err=0.
REQ-024 SHALL cover backpressure: c_rdy=0 for 6 cycles while 4 z arrive -> z_rdy falls after the 4th push; c holds its value; all 4 results emerge in order after c_rdy=1.
REQ-025 SHALL cover overflow: 5th z_vld while the FIFO is full -> err=1, FSM in FAULT, all rdy and c_vld at 0 until a_rst_n pulses.
REQ-026 SHALL cover misaligned last and reset: e_last on the 2nd coefficient -> err=1, with c_last still on the 4th; a_rst_n low mid-polynomial -> outputs cleared at once, next fire is count 0.
